count_wrap_monitor: RTL and testbench

Downstream observer for the 5-to-31 synchronous up/down counter. It samples the counter's output value, load strobe and mode each cycle. It classifies every transition as hold, step, wrap-up, wrap-down or illegal, and keeps a saturating wrap tally with a sticky alarm. An FSM resynchronises after loads and latches a fault on illegal transitions.

---
 rtl/count_wrap_monitor_if.sv | 28 ++
 rtl/count_wrap_monitor.sv | 148 ++++++++++++++
 tb/tb_count_wrap_monitor.sv | 135 +++++++++++++
 3 files changed

// File: rtl/count_wrap_monitor_if.sv
// Bus between the up/down counter environment and count_wrap_monitor.
// The master side drives the counter observation and clear; the slave
// (the monitor) drives the event, status and tally outputs.
interface count_wrap_monitor_if #(
  parameter int WIDTH      = 5,
  parameter int WRAP_CNT_W = 8
);
  logic [WIDTH-1:0]      q_in;
  logic                  load_in;
  logic                  mode_in;
  logic                  clr;
  logic                  wrap_up_pulse;
  logic                  wrap_dn_pulse;
  logic                  step_err;
  logic                  fault;
  logic                  alarm;
  logic [WRAP_CNT_W-1:0] wrap_count;

  modport master (
    output q_in, load_in, mode_in, clr,
    input  wrap_up_pulse, wrap_dn_pulse, step_err, fault, alarm, wrap_count
  );

  modport slave (
    input  q_in, load_in, mode_in, clr,
    output wrap_up_pulse, wrap_dn_pulse, step_err, fault, alarm, wrap_count
  );
endinterface

// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: observes an LO..HI up/down counter, classifies each
// transition, pulses on wraps and illegal steps, keeps a saturating wrap
// tally with a sticky alarm.
// Optional feature macro: COUNT_MONITOR_DIR_CHECK_EN -- when defined, steps
// and wraps that disagree with the counter direction are flagged illegal.
//
// state | meaning
// SYNC  | capture current sample as baseline, no classification
// TRACK | classify every sample against the previous one
// FAULT | illegal transition seen; frozen until load_in or clr
module count_wrap_monitor #(
  parameter int LO          = 5,
  parameter int HI          = 31,
  parameter int WIDTH       = 5,
  parameter int WRAP_CNT_W  = 8,
  parameter int ALARM_WRAPS = 4
) (
  input logic clk,
  input logic rst,
  count_wrap_monitor_if.slave bus
);

  localparam logic [WIDTH-1:0]      LO_V    = WIDTH'(LO);
  localparam logic [WIDTH-1:0]      HI_V    = WIDTH'(HI);
  localparam logic [WRAP_CNT_W-1:0] ALARM_V = WRAP_CNT_W'(ALARM_WRAPS);
  localparam logic [WRAP_CNT_W-1:0] CNT_MAX = {WRAP_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]      q_prev;
  logic                  mode_prev;
  logic                  up_q, dn_q, err_q, fault_q, alarm_q;
  logic [WRAP_CNT_W-1:0] tally_q;

  logic                  up_nx, dn_nx, err_nx, fault_nx, alarm_nx;
  logic [WRAP_CNT_W-1:0] tally_nx;

  logic in_range, is_hold, is_up, is_dn, is_wrap_up, is_wrap_dn;
  logic up_dir_ok, dn_dir_ok, illegal;

  // Raw transition shape of the current sample against the baseline.
  always_comb begin
    in_range   = (bus.q_in >= LO_V) && (bus.q_in <= HI_V);
    is_hold    = (bus.q_in == q_prev);
    is_up      = (q_prev != HI_V) && (bus.q_in == q_prev + 1'b1);
    is_dn      = (q_prev != LO_V) && (bus.q_in == q_prev - 1'b1);
    is_wrap_up = (q_prev == HI_V) && (bus.q_in == LO_V);
    is_wrap_dn = (q_prev == LO_V) && (bus.q_in == HI_V);
  end

`ifdef COUNT_MONITOR_DIR_CHECK_EN
  // mode_prev is the direction that produced the current sample.
  assign up_dir_ok = ~mode_prev;
  assign dn_dir_ok = mode_prev;
`else
  // Direction ignored in this build; mode_prev is kept only as a register.
  logic unused_mode_prev;
  assign unused_mode_prev = mode_prev;
  assign up_dir_ok = 1'b1;
  assign dn_dir_ok = 1'b1;
`endif

  // Anything that is not a hold or a direction-consistent step/wrap is illegal.
  always_comb begin
    illegal = ~in_range |
              ~(is_hold |
                ((is_up | is_wrap_up) & up_dir_ok) |
                ((is_dn | is_wrap_dn) & dn_dir_ok));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_nx;
  end

  // Next-state: clr beats load_in, load_in beats the classification result.
  always_comb begin
    state_nx = state;
    if (bus.clr) begin
      state_nx = SYNC;
    end else begin
      case (state)
        SYNC:    state_nx = bus.load_in ? SYNC : TRACK;
        TRACK:   state_nx = bus.load_in ? SYNC : (illegal ? FAULT : TRACK);
        FAULT:   state_nx = bus.load_in ? SYNC : FAULT;
        default: state_nx = SYNC;
      endcase
    end
  end

  // Output next-values; events are only produced while tracking, and clr
  // still lets a concurrent wrap pulse through while zeroing tally and alarm.
  always_comb begin
    up_nx    = 1'b0;
    dn_nx    = 1'b0;
    err_nx   = 1'b0;
    tally_nx = tally_q;
    if (state == TRACK) begin
      up_nx  = ~illegal & is_wrap_up;
      dn_nx  = ~illegal & is_wrap_dn;
      err_nx = illegal;
    end
    if (bus.clr)
      tally_nx = '0;
    else if ((up_nx | dn_nx) && (tally_q != CNT_MAX))
      tally_nx = tally_q + 1'b1;
    alarm_nx = bus.clr ? 1'b0 : (alarm_q | (tally_nx >= ALARM_V));
    fault_nx = (state_nx == FAULT);
  end

  // Sample registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_prev    <= '0;
      mode_prev <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      err_q     <= 1'b0;
      fault_q   <= 1'b0;
      alarm_q   <= 1'b0;
      tally_q   <= '0;
    end else begin
      q_prev    <= bus.q_in;
      mode_prev <= bus.mode_in;
      up_q      <= up_nx;
      dn_q      <= dn_nx;
      err_q     <= err_nx;
      fault_q   <= fault_nx;
      alarm_q   <= alarm_nx;
      tally_q   <= tally_nx;
    end
  end

  assign bus.wrap_up_pulse = up_q;
  assign bus.wrap_dn_pulse = dn_q;
  assign bus.step_err      = err_q;
  assign bus.fault         = fault_q;
  assign bus.alarm         = alarm_q;
  assign bus.wrap_count    = tally_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor; inputs change 1 ns after a rising
// edge and outputs are checked 1 ns after the following rising edge.
module tb_count_wrap_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  count_wrap_monitor_if #(.WIDTH(5), .WRAP_CNT_W(8)) bus ();

  count_wrap_monitor #(
    .LO(5), .HI(31), .WIDTH(5), .WRAP_CNT_W(8), .ALARM_WRAPS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int q, input bit ld, input bit md, input bit cl);
    bus.q_in    = 5'(q);
    bus.load_in = ld;
    bus.mode_in = md;
    bus.clr     = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int up, input int dn,
                         input int err, input int flt, input int alm,
                         input int cnt);
    chk({tag, ".up"},    int'(bus.wrap_up_pulse), up);
    chk({tag, ".dn"},    int'(bus.wrap_dn_pulse), dn);
    chk({tag, ".err"},   int'(bus.step_err), err);
    chk({tag, ".fault"}, int'(bus.fault), flt);
    chk({tag, ".alarm"}, int'(bus.alarm), alm);
    chk({tag, ".cnt"},   int'(bus.wrap_count), cnt);
  endtask

  initial begin
    bus.q_in = 5'd5; bus.load_in = 1'b0; bus.mode_in = 1'b0; bus.clr = 1'b0;

    // reset
    rst = 1'b1;
    step(5, 0, 0, 0);
    step(5, 0, 0, 0);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // legal up steps after SYNC
    step(5, 0, 0, 0); chk_all("sync5", 0, 0, 0, 0, 0, 0);
    step(6, 0, 0, 0); chk_all("up6",   0, 0, 0, 0, 0, 0);
    step(7, 0, 0, 0); chk_all("up7",   0, 0, 0, 0, 0, 0);
    step(8, 0, 0, 0); chk_all("up8",   0, 0, 0, 0, 0, 0);

    // reposition via load, then wrap up
    step(8, 1, 0, 0);  chk_all("ld8",    0, 0, 0, 0, 0, 0);
    step(30, 0, 0, 0); chk_all("sync30", 0, 0, 0, 0, 0, 0);
    step(31, 0, 0, 0); chk_all("up31",   0, 0, 0, 0, 0, 0);
    step(5, 0, 0, 0);  chk_all("wrapup", 1, 0, 0, 0, 0, 1);
    step(6, 0, 1, 0);  chk_all("after_wrapup", 0, 0, 0, 0, 0, 1);

    // down direction, wrap down
    step(5, 0, 1, 0);  chk_all("dn5",    0, 0, 0, 0, 0, 1);
    step(31, 0, 1, 0); chk_all("wrapdn", 0, 1, 0, 0, 0, 2);
    step(30, 0, 1, 0); chk_all("dn30",   0, 0, 0, 0, 0, 2);

    // load sequence: pre-load data classified, loaded value only captured
    step(30, 1, 1, 0); chk_all("ld30",   0, 0, 0, 0, 0, 2);
    step(12, 0, 0, 0); chk_all("sync12", 0, 0, 0, 0, 0, 2);
    step(12, 1, 0, 0); chk_all("ld12",   0, 0, 0, 0, 0, 2);
    step(20, 0, 0, 0); chk_all("sync20", 0, 0, 0, 0, 0, 2);
    step(21, 0, 0, 0); chk_all("up21",   0, 0, 0, 0, 0, 2);

    // illegal jump 10 -> 14, FAULT freezes, clr exits
    step(21, 1, 0, 0); chk_all("ld21",   0, 0, 0, 0, 0, 2);
    step(10, 0, 0, 0); chk_all("sync10", 0, 0, 0, 0, 0, 2);
    step(14, 0, 0, 0); chk_all("jump14", 0, 0, 1, 1, 0, 2);
    step(31, 0, 0, 0); chk_all("flt31",  0, 0, 0, 1, 0, 2);
    step(5, 0, 0, 0);  chk_all("flt5",   0, 0, 0, 1, 0, 2);
    step(5, 0, 0, 1);  chk_all("fltclr", 0, 0, 0, 0, 0, 0);

    // out-of-range value, then load exits FAULT
    step(5, 0, 0, 0);  chk_all("sync5b", 0, 0, 0, 0, 0, 0);
    step(3, 0, 0, 0);  chk_all("range3", 0, 0, 1, 1, 0, 0);
    step(5, 1, 0, 0);  chk_all("fltld",  0, 0, 0, 0, 0, 0);

    // four wraps -> alarm on the 4th
    for (int i = 1; i <= 4; i++) begin
      step(31, 0, 0, 0);
      step(5, 0, 0, 0);
      chk_all($sformatf("wrap%0d", i), 1, 0, 0, 0, (i >= 4) ? 1 : 0, i);
      step(5, 1, 0, 0);
      chk($sformatf("wrap%0d_ld.up", i), int'(bus.wrap_up_pulse), 0);
    end

    // clr concurrent with a wrap: pulse still emitted, tally and alarm zeroed
    step(31, 0, 0, 0); chk_all("pre_clrwrap", 0, 0, 0, 0, 1, 4);
    step(5, 0, 0, 1);  chk_all("clrwrap",     1, 0, 0, 0, 0, 0);

    // up step while counter mode is down
    step(9, 0, 1, 0);  chk_all("sync9", 0, 0, 0, 0, 0, 0);
    step(10, 0, 1, 0);
`ifdef COUNT_MONITOR_DIR_CHECK_EN
    chk_all("dir10", 0, 0, 1, 1, 0, 0);
`else
    chk_all("dir10", 0, 0, 0, 0, 0, 0);
`endif
    step(10, 0, 0, 1); chk_all("dirclr", 0, 0, 0, 0, 0, 0);

    // tally saturation after 256 wraps
    for (int i = 0; i < 256; i++) begin
      step(31, 0, 0, 0);
      step(5, 0, 0, 0);
      step(5, 1, 0, 0);
    end
    chk_all("sat", 0, 0, 0, 0, 1, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
